instr_fetch: RTL and testbench

Fetch stage of the 19-bit CPU: owns the program counter, drives the synchronous instruction memory, and presents one registered 19-bit instruction per cycle to the instruction parser. It accepts resolved control-flow strobes (jump, taken branch, call, ret) from the decode/execute side. It keeps an internal return-address stack for call/ret, and stops fetching on stack overflow or underflow.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_return_stack.sv | 38 +++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, fetch states and fault codes for the fetch stage
package instr_fetch_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 19;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FAULT
  } fetch_state_t;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;

endpackage

// File: rtl/instr_fetch_return_stack.sv
// rtl/instr_fetch_return_stack.sv - return-address stack; sp counts live entries (0..DEPTH)
module return_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11,
  localparam int SP_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] ras [DEPTH];

  // Index arithmetic is modulo DEPTH, so sp==DEPTH still reads the last slot.
  assign top_data = ras[sp[IDX_W-1:0] - IDX_W'(1)];
  assign full     = (sp == SP_W'(DEPTH));
  assign empty    = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push) begin
      ras[sp[IDX_W-1:0]] <= push_data;
      sp                 <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, redirect mux, return stack and registered instruction output
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int RAS_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [7:0]         branch_target,
  input  logic               call_en,
  input  logic [ADDR_W-1:0]  call_target,
  input  logic               ret_en,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int SP_W = $clog2(RAS_DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q, pc_inc, ret_addr, target, ras_top;
  logic              accept, do_ret, do_call, do_jump, do_branch;
  logic              ovf, unf, push, pop, redirect;
  logic [SP_W-1:0]   ras_sp;
  logic              ras_full, ras_empty;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top_data  (ras_top),
    .sp        (ras_sp),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    accept    = (state == S_RUN) && instr_valid && !stall;
    do_ret    = accept && ret_en;
    do_call   = accept && call_en && !ret_en;
    do_jump   = accept && jump_en && !ret_en && !call_en;
    do_branch = accept && branch_taken && !ret_en && !call_en && !jump_en;
    unf       = do_ret && ras_empty;
    ovf       = do_call && ras_full;
    pop       = do_ret && (ras_sp != '0);
    push      = do_call && !ras_full;
    redirect  = pop || push || do_jump || do_branch;
    pc_inc    = pc_q + ADDR_W'(1);
    ret_addr  = instr_pc + ADDR_W'(1);

    target = ADDR_W'(branch_target);
    if (pop)          target = ras_top;
    else if (push)    target = call_target;
    else if (do_jump) target = jump_target;

    // Stalls and faults re-issue pc_q so the word in the memory register stays aligned with it.
    imem_addr = pc_q;
    case (state)
      S_BOOT:  imem_addr = '0;
      S_RUN:   if (!stall && !unf && !ovf) imem_addr = redirect ? target : pc_inc;
      default: imem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      pc_q        <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FAULT_NONE;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_RUN;
          pc_q  <= '0;
        end
        S_RUN: begin
          if (!stall) begin
            if (ovf || unf) begin
              state       <= S_FAULT;
              fault       <= 1'b1;
              fault_code  <= ovf ? FAULT_OVERFLOW : FAULT_UNDERFLOW;
              instr_valid <= 1'b0;
            end else if (redirect) begin
              instr_valid <= 1'b0;
              pc_q        <= target;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc_q;
              instr_valid <= 1'b1;
              pc_q        <= pc_inc;
            end
          end
        end
        default: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a word-equals-address instruction memory
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        stall, jump_en, branch_taken, call_en, ret_en;
  logic [10:0] jump_target, call_target;
  logic [7:0]  branch_target;
  logic [18:0] instr;
  logic [10:0] instr_pc;
  logic        instr_valid, fault;
  logic [1:0]  fault_code;

  int checks   = 0;
  int failures = 0;

  logic [18:0] mem [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  instr_fetch #(.RAS_DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call_en       (call_en),
    .call_target   (call_target),
    .ret_en        (ret_en),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input string tag, input int pc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, ".instr"}, 32'(instr), 32'(pc));
  endtask

  task automatic do_jump(input logic [10:0] tgt);
    jump_en = 1'b1; jump_target = tgt;
    tick();
    jump_en = 1'b0;
    chk("jump_bubble", 32'(instr_valid), 32'd0);
    tick();
  endtask

  task automatic do_call(input logic [10:0] tgt);
    call_en = 1'b1; call_target = tgt;
    tick();
    call_en = 1'b0;
    tick();
  endtask

  task automatic do_ret();
    ret_en = 1'b1;
    tick();
    ret_en = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 19'(i);
    rst = 1'b1; stall = 1'b0; jump_en = 1'b0; branch_taken = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    jump_target = '0; call_target = '0; branch_target = '0;
    tick(); tick();
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.pc", 32'(instr_pc), 32'd0);
    chk("rst.instr", 32'(instr), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.code", 32'(fault_code), 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);

    // Sequential fetch from reset
    rst = 1'b0;
    tick();
    chk("edge1.valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_instr("seq", i);
    end

    // Jump at instr_pc=5 to 0x100
    jump_en = 1'b1; jump_target = 11'h100;
    #1 chk("jump.addr", 32'(imem_addr), 32'h100);
    tick();
    jump_en = 1'b0;
    chk("jump.bubble", 32'(instr_valid), 32'd0);
    tick(); expect_instr("jump.t0", 'h100);
    tick(); expect_instr("jump.t1", 'h101);

    // Call at 0x10, return to 0x11
    do_jump(11'h010); expect_instr("pre_call", 'h10);
    do_call(11'h040); expect_instr("call.t", 'h40);
    tick(); expect_instr("call.t1", 'h41);
    ret_en = 1'b1;
    #1 chk("ret.addr", 32'(imem_addr), 32'h11);
    tick(); ret_en = 1'b0;
    chk("ret.bubble", 32'(instr_valid), 32'd0);
    tick(); expect_instr("ret.t", 'h11);

    // Three nested calls, LIFO returns
    do_call(11'h200); expect_instr("n1", 'h200);
    do_call(11'h300); expect_instr("n2", 'h300);
    do_call(11'h400); expect_instr("n3", 'h400);
    do_ret(); expect_instr("r3", 'h301);
    do_ret(); expect_instr("r2", 'h201);
    do_ret(); expect_instr("r1", 'h12);

    // Three-cycle stall at instr_pc=7
    do_jump(11'h005); expect_instr("pre_stall5", 5);
    tick(); tick(); expect_instr("pre_stall7", 7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.addr", 32'(imem_addr), 32'd8);
      jump_en = 1'b1; jump_target = 11'h333;
      tick();
      jump_en = 1'b0;
      expect_instr("stall.hold", 7);
    end
    stall = 1'b0;
    tick(); expect_instr("stall.rel8", 8);
    tick(); expect_instr("stall.rel9", 9);

    // PC wrap 2047 -> 0
    do_jump(11'h7FE); expect_instr("wrap.7fe", 'h7FE);
    tick(); expect_instr("wrap.7ff", 'h7FF);
    chk("wrap.addr", 32'(imem_addr), 32'd1);
    tick(); expect_instr("wrap.0", 0);
    tick(); expect_instr("wrap.1", 1);

    // ret and jump together: ret wins
    do_call(11'h050); expect_instr("pri.call", 'h50);
    ret_en = 1'b1; jump_en = 1'b1; jump_target = 11'h123;
    #1 chk("pri.addr", 32'(imem_addr), 32'd2);
    tick(); ret_en = 1'b0; jump_en = 1'b0;
    tick(); expect_instr("pri.ret", 2);

    // Taken branch, zero-extended target
    branch_taken = 1'b1; branch_target = 8'hF0;
    #1 chk("br.addr", 32'(imem_addr), 32'h0F0);
    tick(); branch_taken = 1'b0;
    chk("br.bubble", 32'(instr_valid), 32'd0);
    tick(); expect_instr("br.t", 'hF0);

    // Overflow on the 17th nested call
    for (int i = 0; i < 16; i++) do_call(11'h600);
    expect_instr("ovf.pre", 'h600);
    call_en = 1'b1; call_target = 11'h600;
    #1 chk("ovf.addr", 32'(imem_addr), 32'h601);
    tick(); call_en = 1'b0;
    chk("ovf.fault", 32'(fault), 32'd1);
    chk("ovf.code", 32'(fault_code), 32'd1);
    chk("ovf.valid", 32'(instr_valid), 32'd0);
    tick(); tick();
    chk("ovf.valid_hold", 32'(instr_valid), 32'd0);
    chk("ovf.addr_hold", 32'(imem_addr), 32'h601);
    chk("ovf.sticky", 32'(fault), 32'd1);
    rst = 1'b1;
    tick();
    chk("ovf.rst_fault", 32'(fault), 32'd0);
    chk("ovf.rst_code", 32'(fault_code), 32'd0);
    rst = 1'b0;

    // Underflow: ret right after reset (stack must be empty again)
    tick(); tick(); expect_instr("unf.pre", 0);
    ret_en = 1'b1;
    tick(); ret_en = 1'b0;
    chk("unf.fault", 32'(fault), 32'd1);
    chk("unf.code", 32'(fault_code), 32'd2);
    chk("unf.valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("unf.rst_fault", 32'(fault), 32'd0);
    chk("unf.rst_code", 32'(fault_code), 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
